// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Brief    : Data-memory slave for the core data port. Registered read with
//             write-first bypass, post-reset zero sweep, sticky fault capture,
//             read/write access counters.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter bit          CLEAR_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_re,
  input  logic [31:0] data_raddr,
  output logic [31:0] data_rdata,
  input  logic        data_we,
  input  logic [31:0] data_waddr,
  input  logic [31:0] data_wdata,
  output logic        busy,
  output logic        err,
  output logic [31:0] err_addr,
  input  logic        err_clr,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);

  localparam int unsigned c_aw   = $clog2(DEPTH);
  localparam logic [32:0] c_span = 33'(DEPTH) << 2;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [c_aw-1:0] r_idx, w_idx_nxt;
  logic [31:0]     r_mem [0:DEPTH-1];
  logic [31:0]     r_rdata, r_err_addr, r_rd_cnt, r_wr_cnt;
  logic            r_err;

  logic [31:0]     w_roff, w_woff;
  logic [c_aw-1:0] w_ridx, w_widx, w_mem_addr;
  logic [31:0]     w_mem_din;
  logic            w_rlegal, w_wlegal, w_ready, w_clearing, w_mem_we;
  logic            w_rd_ok, w_rd_bad, w_wr_ok, w_wr_bad, w_fault, w_clr;

  // Offsets are only meaningful when addr >= ADDR_BASE; the 33-bit span
  // compare keeps a full 4 GiB window from overflowing.
  assign w_roff   = data_raddr - ADDR_BASE;
  assign w_woff   = data_waddr - ADDR_BASE;
  assign w_rlegal = (data_raddr[1:0] == 2'b00) && (data_raddr >= ADDR_BASE) &&
                    ({1'b0, w_roff} < c_span);
  assign w_wlegal = (data_waddr[1:0] == 2'b00) && (data_waddr >= ADDR_BASE) &&
                    ({1'b0, w_woff} < c_span);
  assign w_ridx   = w_roff[c_aw+1:2];
  assign w_widx   = w_woff[c_aw+1:2];

  assign w_ready    = (r_state == ST_READY);
  assign w_clearing = (r_state == ST_CLEAR);
  assign w_rd_ok    = w_ready & data_re & w_rlegal;
  assign w_rd_bad   = w_ready & data_re & ~w_rlegal;
  assign w_wr_ok    = w_ready & data_we & w_wlegal;
  assign w_wr_bad   = w_ready & data_we & ~w_wlegal;
  assign w_fault    = w_rd_bad | w_wr_bad;
  assign w_clr      = w_ready & err_clr;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (r_state == ST_CLEAR) begin
      w_idx_nxt = r_idx + c_aw'(1);
      if (r_idx == c_aw'(DEPTH - 1)) begin
        w_state_nxt = ST_READY;
      end
    end
  end

  // Single write port shared between the sweep and the core.
  assign w_mem_we   = rst_n & (w_clearing | w_wr_ok);
  assign w_mem_addr = w_clearing ? r_idx : w_widx;
  assign w_mem_din  = w_clearing ? 32'h0 : data_wdata;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= CLEAR_EN ? ST_CLEAR : ST_READY;
      r_idx      <= '0;
      r_rdata    <= 32'h0;
      r_err      <= 1'b0;
      r_err_addr <= 32'h0;
      r_rd_cnt   <= 32'h0;
      r_wr_cnt   <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_rd_ok) begin
        r_rdata  <= (w_wr_ok && (w_widx == w_ridx)) ? data_wdata : r_mem[w_ridx];
        r_rd_cnt <= r_rd_cnt + 32'd1;
      end else if (w_rd_bad) begin
        r_rdata <= 32'h0;
      end
      if (w_wr_ok) begin
        r_wr_cnt <= r_wr_cnt + 32'd1;
      end
      // A new fault outranks a simultaneous clear; the read address wins ties.
      if (w_fault && (!r_err || w_clr)) begin
        r_err      <= 1'b1;
        r_err_addr <= w_rd_bad ? data_raddr : data_waddr;
      end else if (w_clr) begin
        r_err      <= 1'b0;
        r_err_addr <= 32'h0;
      end
    end
  end

  assign data_rdata = r_rdata;
  assign busy       = w_clearing;
  assign err        = r_err;
  assign err_addr   = r_err_addr;
  assign rd_cnt     = r_rd_cnt;
  assign wr_cnt     = r_wr_cnt;

endmodule
`default_nettype wire
